// File: rtl/dm_load_ext.sv
// dm_load_ext -- M->W load data path: lane select, zero/sign extension, AdEL detection.
// Revision 1.0
`default_nettype none

module dm_load_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_W,
  input  logic        flush_W,
  input  logic        memread_M,
  input  logic [2:0]  loadop_M,
  input  logic [1:0]  addr_M,
  input  logic [31:0] readdata_M,
  input  logic [4:0]  rd_M,
  output logic [31:0] loaddata_W,
  output logic        regwrite_ld_W,
  output logic [4:0]  rd_W,
  output logic        adel_W
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LH  = 3'b100;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ext_val;
  logic        op_valid;
  logic        aligned;

  logic [31:0] nxt_data;
  logic        nxt_we;
  logic [4:0]  nxt_rd;
  logic        nxt_adel;

  always_comb begin
    case (addr_M)
      2'd0:    byte_lane = readdata_M[7:0];
      2'd1:    byte_lane = readdata_M[15:8];
      2'd2:    byte_lane = readdata_M[23:16];
      default: byte_lane = readdata_M[31:24];
    endcase
    half_lane = addr_M[1] ? readdata_M[31:16] : readdata_M[15:0];
  end

  always_comb begin
    ext_val  = 32'd0;
    op_valid = 1'b1;
    aligned  = 1'b1;
    case (loadop_M)
      OP_LW: begin
        ext_val = readdata_M;
        aligned = (addr_M == 2'b00);
      end
      OP_LBU: ext_val = {24'd0, byte_lane};
      OP_LB:  ext_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LHU: begin
        ext_val = {16'd0, half_lane};
        aligned = ~addr_M[0];
      end
      OP_LH: begin
        ext_val = {{16{half_lane[15]}}, half_lane};
        aligned = ~addr_M[0];
      end
      default: op_valid = 1'b0;
    endcase
  end

  // A misaligned load becomes an AdEL marker with no write-back.
  always_comb begin
    nxt_data = 32'd0;
    nxt_we   = 1'b0;
    nxt_rd   = 5'd0;
    nxt_adel = 1'b0;
    if (memread_M && op_valid) begin
      if (aligned) begin
        nxt_data = ext_val;
        nxt_we   = (rd_M != 5'd0);
        nxt_rd   = rd_M;
      end else begin
        nxt_adel = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaddata_W    <= 32'd0;
      regwrite_ld_W <= 1'b0;
      rd_W          <= 5'd0;
      adel_W        <= 1'b0;
    end else if (flush_W) begin
      loaddata_W    <= 32'd0;
      regwrite_ld_W <= 1'b0;
      rd_W          <= 5'd0;
      adel_W        <= 1'b0;
    end else if (!stall_W) begin
      loaddata_W    <= nxt_data;
      regwrite_ld_W <= nxt_we;
      rd_W          <= nxt_rd;
      adel_W        <= nxt_adel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_load_ext.sv
// tb_dm_load_ext -- directed and randomized checks of dm_load_ext against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_dm_load_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_W = 1'b0;
  logic        flush_W = 1'b0;
  logic        memread_M = 1'b0;
  logic [2:0]  loadop_M = 3'd0;
  logic [1:0]  addr_M = 2'd0;
  logic [31:0] readdata_M = 32'd0;
  logic [4:0]  rd_M = 5'd0;
  logic [31:0] loaddata_W;
  logic        regwrite_ld_W;
  logic [4:0]  rd_W;
  logic        adel_W;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        we;
    logic [4:0]  rd;
    logic        adel;
  } w_t;

  w_t exp_w = '0;

  dm_load_ext dut (
    .clk(clk), .reset(reset), .stall_W(stall_W), .flush_W(flush_W),
    .memread_M(memread_M), .loadop_M(loadop_M), .addr_M(addr_M),
    .readdata_M(readdata_M), .rd_M(rd_M), .loaddata_W(loaddata_W),
    .regwrite_ld_W(regwrite_ld_W), .rd_W(rd_W), .adel_W(adel_W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: decode from the load rules with plain integer arithmetic.
  function automatic w_t model(input logic mr, input int op, input int a,
                               input logic [31:0] word, input int rd);
    w_t r;
    longint v;
    bit ok;
    r = '0;
    ok = 1;
    v = 0;
    if (!mr || op > 4) return r;
    case (op)
      0: begin ok = (a == 0); v = longint'(word); end
      1: v = (longint'(word) >> (8 * a)) % 256;
      2: begin
        v = (longint'(word) >> (8 * a)) % 256;
        if (v >= 128) v = v - 256;
      end
      3: begin ok = (a % 2 == 0); v = (longint'(word) >> (16 * (a / 2))) % 65536; end
      default: begin
        ok = (a % 2 == 0);
        v = (longint'(word) >> (16 * (a / 2))) % 65536;
        if (v >= 32768) v = v - 65536;
      end
    endcase
    if (!ok) begin
      r.adel = 1'b1;
    end else begin
      r.d  = v[31:0];
      r.we = (rd != 0);
      r.rd = (rd != 0) ? 5'(rd) : 5'd0;
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data"}, loaddata_W, exp_w.d);
    chk({tag, ".we"}, {31'd0, regwrite_ld_W}, {31'd0, exp_w.we});
    chk({tag, ".rd"}, {27'd0, rd_W}, {27'd0, exp_w.rd});
    chk({tag, ".adel"}, {31'd0, adel_W}, {31'd0, exp_w.adel});
  endtask

  // Drive M-stage inputs, clock one edge, advance the model and compare.
  task automatic step(input string tag, input logic mr, input logic [2:0] op,
                      input logic [1:0] a, input logic [31:0] word, input logic [4:0] rd,
                      input logic st, input logic fl);
    memread_M = mr; loadop_M = op; addr_M = a; readdata_M = word; rd_M = rd;
    stall_W = st; flush_W = fl;
    @(posedge clk);
    if (fl) exp_w = '0;
    else if (!st) exp_w = model(mr, int'(op), int'(a), word, int'(rd));
    #1;
    check_all(tag);
  endtask

  localparam logic [31:0] W = 32'h8765_43A1;

  initial begin
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Byte loads
    step("lb0",  1, 3'b010, 2'b00, W, 5'd5, 0, 0);
    chk("lb0.lit", loaddata_W, 32'hFFFF_FFA1);
    step("lbu0", 1, 3'b001, 2'b00, W, 5'd5, 0, 0);
    chk("lbu0.lit", loaddata_W, 32'h0000_00A1);
    step("lb1",  1, 3'b010, 2'b01, W, 5'd5, 0, 0);
    chk("lb1.lit", loaddata_W, 32'h0000_0043);
    step("lb3",  1, 3'b010, 2'b11, W, 5'd5, 0, 0);
    chk("lb3.lit", loaddata_W, 32'hFFFF_FF87);
    // Halfword / word
    step("lh2",  1, 3'b100, 2'b10, W, 5'd5, 0, 0);
    chk("lh2.lit", loaddata_W, 32'hFFFF_8765);
    step("lhu0", 1, 3'b011, 2'b00, W, 5'd5, 0, 0);
    chk("lhu0.lit", loaddata_W, 32'h0000_43A1);
    step("lw0",  1, 3'b000, 2'b00, W, 5'd5, 0, 0);
    chk("lw0.lit", loaddata_W, W);
    // Misalignment
    step("lh1",  1, 3'b100, 2'b01, W, 5'd5, 0, 0);
    chk("lh1.adel", {31'd0, adel_W}, 32'd1);
    step("lw2",  1, 3'b000, 2'b10, W, 5'd5, 0, 0);
    chk("lw2.adel", {31'd0, adel_W}, 32'd1);
    step("lbu3", 1, 3'b001, 2'b11, W, 5'd5, 0, 0);
    chk("lbu3.adel", {31'd0, adel_W}, 32'd0);

    // Stall holds, then stall+flush gives a bubble
    step("lwS", 1, 3'b000, 2'b00, 32'h1234_5678, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 3'b010, 2'(i), $urandom, 5'(i + 1), 1, 0);
      chk("stall.lit", loaddata_W, 32'h1234_5678);
    end
    step("stflush", 1, 3'b000, 2'b00, W, 5'd3, 1, 1);
    chk("stflush.we", {31'd0, regwrite_ld_W}, 32'd0);

    // Edge cases
    step("rd0",   1, 3'b000, 2'b00, W, 5'd0, 0, 0);
    chk("rd0.lit", loaddata_W, W);
    step("resop", 1, 3'b110, 2'b00, W, 5'd7, 0, 0);
    step("nord",  0, 3'b000, 2'b00, W, 5'd7, 0, 0);

    // Asynchronous reset mid-cycle with a valid load held
    step("prerst", 1, 3'b000, 2'b00, 32'hCAFE_F00D, 5'd12, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    exp_w = '0;
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    #2;
    reset = 1'b1;
    #1;
    check_all("rst_release");
    step("post_rst", 1, 3'b011, 2'b10, W, 5'd4, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           2'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
